// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXE/MEM/WB control FSM for a MIPS subset core.
// Optional macro ILLEGAL_TRAP_EN: unknown instructions halt the FSM (sticky illegal) instead of acting as NOPs.
module mc_ctrl #(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       ir_we,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic [1:0] EOp,
  output logic       mem_req,
  output logic       mem_we,
  output logic       instr_done,
  output logic       mem_err,
  output logic       illegal,
  output logic [3:0] state
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT_MAX - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXE = 4'd3, S_MEM = 4'd4,
    S_WB = 4'd5, S_BR = 4'd6, S_JMP = 4'd7, S_HALT = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_JR, I_BAD
  } instr_t;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [1:0] eop;
    logic       mem_req;
    logic       mem_we;
    logic       done;
    logic       illegal;
  } ctl_t;

  state_t        state_q, state_d;
  logic [5:0]    op_q, op_d, fn_q, fn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctl_t          ctl_q, ctl_d;
  instr_t        cur;
  logic          sw_done, timeout, nop_done;

  function automatic instr_t classify(input logic [5:0] op, input logic [5:0] fn);
    instr_t r;
    r = I_BAD;
    case (op)
      6'h00: begin
        case (fn)
          6'h21:   r = I_ADDU;
          6'h23:   r = I_SUBU;
          6'h08:   r = I_JR;
          default: r = I_BAD;
        endcase
      end
      6'h0d:   r = I_ORI;
      6'h0f:   r = I_LUI;
      6'h23:   r = I_LW;
      6'h2b:   r = I_SW;
      6'h04:   r = I_BEQ;
      6'h02:   r = I_J;
      6'h03:   r = I_JAL;
      default: r = I_BAD;
    endcase
    return r;
  endfunction

  always_comb begin
    // IR is only trustworthy from DECODE on; DECODE sees it live, later states use the latched copy.
    cur     = (state_q == S_DECODE) ? classify(opcode, funct) : classify(op_q, fn_q);
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
    cnt_d   = '0;
    sw_done = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        fn_d = funct;
        case (cur)
          I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW: state_d = S_EXE;
          I_BEQ:            state_d = S_BR;
          I_J, I_JAL, I_JR: state_d = S_JMP;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_EXE: state_d = (cur == I_LW || cur == I_SW) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ack) begin
          state_d = (cur == I_LW) ? S_WB : S_FETCH;
          sw_done = (cur == I_SW);
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB, S_BR, S_JMP: state_d = S_FETCH;
      S_HALT:            state_d = S_HALT;
      default:           state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copy lines up with state_q.
    ctl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctl_d.ir_we = 1'b1;
        ctl_d.pc_we = 1'b1;
      end
      S_DECODE: ctl_d.eop = 2'b11;
      S_EXE: begin
        case (cur)
          I_SUBU: ctl_d.alu_op = 2'b01;
          I_ORI: begin
            ctl_d.alu_src = 1'b1;
            ctl_d.alu_op  = 2'b10;
            ctl_d.eop     = 2'b01;
          end
          I_LUI: begin
            ctl_d.alu_src = 1'b1;
            ctl_d.alu_op  = 2'b11;
            ctl_d.eop     = 2'b10;
          end
          I_LW, I_SW: ctl_d.alu_src = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        ctl_d.mem_req = 1'b1;
        ctl_d.mem_we  = (cur == I_SW);
      end
      S_WB: begin
        ctl_d.reg_we = 1'b1;
        ctl_d.done   = 1'b1;
        case (cur)
          I_ADDU, I_SUBU: ctl_d.reg_dst = 2'b01;
          I_LW:           ctl_d.wd_sel  = 2'b01;
          default: ;
        endcase
      end
      S_BR: begin
        ctl_d.alu_op  = 2'b01;
        ctl_d.eop     = 2'b11;
        ctl_d.npc_sel = 2'b01;
        ctl_d.done    = 1'b1;
      end
      S_JMP: begin
        ctl_d.pc_we   = 1'b1;
        ctl_d.done    = 1'b1;
        ctl_d.npc_sel = (cur == I_JR) ? 2'b11 : 2'b10;
        if (cur == I_JAL) begin
          ctl_d.reg_we  = 1'b1;
          ctl_d.reg_dst = 2'b10;
          ctl_d.wd_sel  = 2'b10;
        end
      end
      S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        ctl_d.illegal = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign nop_done = 1'b0;
`else
  assign nop_done = (state_q == S_DECODE) && (cur == I_BAD);
`endif

  // The branch decision needs the ALU compare made in S_BR itself.
  assign pc_we      = ctl_q.pc_we | ((state_q == S_BR) & zero);
  assign npc_sel    = ctl_q.npc_sel;
  assign ir_we      = ctl_q.ir_we;
  assign reg_we     = ctl_q.reg_we;
  assign reg_dst    = ctl_q.reg_dst;
  assign wd_sel     = ctl_q.wd_sel;
  assign alu_src    = ctl_q.alu_src;
  assign alu_op     = ctl_q.alu_op;
  assign EOp        = ctl_q.eop;
  assign mem_req    = ctl_q.mem_req;
  assign mem_we     = ctl_q.mem_we;
  assign instr_done = ctl_q.done | sw_done | nop_done;
  assign mem_err    = timeout;
  assign illegal    = ctl_q.illegal;
  assign state      = state_q;
endmodule
